sequence_checker: RTL and testbench

// Downstream monitor for the 3-bit sequence_counter output. Samples the code stream,

---
 rtl/seq_pkg.sv | 37 +++
 rtl/sequence_checker_sat_counter.sv | 35 +++
 rtl/sequence_checker.sv | 158 +++++++++++++++
 tb/tb_sequence_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 3-bit sequence_counter code stream.
//   code_t      : 3-bit code type
//   S0..S7      : named code constants
//   START_CODE_DEF : code that begins one full 8-step cycle
//   succ()      : successor of a code in the order 5,4,7,6,1,0,3,2,(5...)
package seq_pkg;

  typedef logic [2:0] code_t;

  localparam code_t S0 = 3'd0;
  localparam code_t S1 = 3'd1;
  localparam code_t S2 = 3'd2;
  localparam code_t S3 = 3'd3;
  localparam code_t S4 = 3'd4;
  localparam code_t S5 = 3'd5;
  localparam code_t S6 = 3'd6;
  localparam code_t S7 = 3'd7;

  localparam code_t START_CODE_DEF = S5;

  // Total over all eight codes, so any sample has a defined successor.
  function automatic code_t succ(input code_t c);
    code_t n;
    case (c)
      S5:      n = S4;
      S4:      n = S7;
      S7:      n = S6;
      S6:      n = S1;
      S1:      n = S0;
      S0:      n = S3;
      S3:      n = S2;
      default: n = S5; // S2
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sequence_checker_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   in  1  clock, posedge
//   rst   in  1  synchronous active-high reset, clears count
//   inc   in  1  increment request for this cycle
//   count out W  current count, registered
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: passive monitor of the sequence_counter code stream.
// Locks onto the order 5,4,7,6,1,0,3,2 and reports out-of-order codes.
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   rst         in   1      synchronous active-high reset
//   code_in     in   3      sampled counter code
//   code_valid  in   1      code_in is a new sample; low holds all state
//   locked      out  1      locked to the sequence
//   error       out  1      one-cycle pulse: last valid sample mismatched while locked
//   expected    out  3      predicted next code (meaningful while locked)
//   err_count   out  CNT_W  mismatches while locked, saturating
//   wrap_count  out  CNT_W  full cycles seen while locked, wrapping
//   state_dbg   out  2      FSM state: 0 SEARCH, 1 LOCKING, 2 LOCKED
//
// Handshake: a sample is consumed on every posedge where code_valid=1 (no
// backpressure); all outputs reflect that sample from the following cycle.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int    LOCK_N     = 3,
  parameter int    UNLOCK_N   = 2,
  parameter int    CNT_W      = 8,
  parameter code_t START_CODE = START_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic             locked,
  output logic             error,
  output logic [2:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_N);

  state_t           state_q,    state_d;
  code_t            prev_q,     prev_d;
  logic [3:0]       match_q,    match_d;
  logic [3:0]       miss_q,     miss_d;
  logic             locked_q,   locked_d;
  logic             error_q,    error_d;
  code_t            expected_q, expected_d;
  logic [CNT_W-1:0] wrap_q,     wrap_d;
  logic             err_inc;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = match_q;
    miss_d     = miss_q;
    locked_d   = locked_q;
    error_d    = 1'b0;
    expected_d = expected_q;
    wrap_d     = wrap_q;
    err_inc    = 1'b0;

    if (code_valid) begin
      case (state_q)
        ST_SEARCH: begin
          prev_d  = code_in;
          match_d = '0;
          state_d = ST_LOCKING;
        end

        ST_LOCKING: begin
          // Any mismatch restarts the run from the new sample; no error
          // is reported before lock.
          prev_d = code_in;
          if (code_in == succ(prev_q)) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == LOCK_CNT) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              expected_d = succ(code_in);
              miss_d     = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: the prediction advances on every sample, so a single
          // corrupted code costs exactly one error and no resync.
          expected_d = succ(expected_q);
          if (code_in == expected_q) begin
            miss_d = '0;
            if (code_in == START_CODE) begin
              wrap_d = wrap_q + CNT_W'(1);
            end
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_q + 4'd1;
            if ((miss_q + 4'd1) == UNLOCK_CNT) begin
              state_d  = ST_SEARCH;
              locked_d = 1'b0;
              match_d  = '0;
            end
          end
        end

        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      prev_q     <= S0;
      match_q    <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      expected_q <= START_CODE;
      wrap_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      expected_q <= expected_d;
      wrap_q     <= wrap_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  assign locked     = locked_q;
  assign error      = error_q;
  assign expected   = expected_q;
  assign wrap_count = wrap_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [2:0] code_in = 3'd0;

  logic       locked, error, locked_s, error_s;
  logic [2:0] expected, expected_s;
  logic [7:0] err_count, wrap_count;
  logic [1:0] err_count_s, wrap_count_s;
  logic [1:0] state_dbg, state_dbg_s;

  always #5 clk = ~clk;

  sequence_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(8), .START_CODE(3'b101)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .locked(locked), .error(error), .expected(expected),
    .err_count(err_count), .wrap_count(wrap_count), .state_dbg(state_dbg)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation/wrap.
  sequence_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2), .START_CODE(3'b101)) dut_s (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .locked(locked_s), .error(error_s), .expected(expected_s),
    .err_count(err_count_s), .wrap_count(wrap_count_s), .state_dbg(state_dbg_s)
  );

  // ---------------- reference model + scoreboard ----------------
  int succ_tab[8] = '{3, 0, 5, 2, 7, 4, 1, 6};

  int         m_st;
  logic [2:0] m_prev, m_ex;
  int         m_match, m_miss, m_ec, m_wc;
  logic       m_lk, m_er;

  // {state, locked, error, expected, err8, wrap8, err2, wrap2}
  logic [26:0] exp_q[$];
  logic [26:0] e;

  int checks = 0;
  int passed = 0;

  function automatic logic [26:0] obs_vec();
    return {state_dbg, locked, error, expected, err_count, wrap_count, err_count_s, wrap_count_s};
  endfunction

  function automatic void model_step(input logic r, input logic v, input logic [2:0] c);
    logic [7:0] ec8;
    logic [1:0] ec2;
    if (r) begin
      m_st = 0; m_prev = 3'd0; m_match = 0; m_miss = 0;
      m_lk = 1'b0; m_er = 1'b0; m_ex = 3'd5; m_ec = 0; m_wc = 0;
    end else if (!v) begin
      m_er = 1'b0;
    end else begin
      m_er = 1'b0;
      case (m_st)
        0: begin
          m_prev = c; m_match = 0; m_st = 1;
        end
        1: begin
          if (int'(c) == succ_tab[m_prev]) begin
            m_match++;
            if (m_match == LOCK_N) begin
              m_st = 2; m_lk = 1'b1; m_ex = 3'(succ_tab[c]); m_miss = 0;
            end
          end else begin
            m_match = 0;
          end
          m_prev = c;
        end
        default: begin
          if (c == m_ex) begin
            m_miss = 0;
            if (c == 3'd5) m_wc++;
          end else begin
            m_er = 1'b1; m_ec++; m_miss++;
            if (m_miss == UNLOCK_N) begin
              m_st = 0; m_lk = 1'b0; m_match = 0;
            end
          end
          m_ex = 3'(succ_tab[m_ex]);
        end
      endcase
    end
    ec8 = (m_ec > 255) ? 8'hff : 8'(m_ec);
    ec2 = (m_ec > 3) ? 2'd3 : 2'(m_ec);
    exp_q.push_back({2'(m_st), m_lk, m_er, m_ex, ec8, 8'(m_wc), ec2, 2'(m_wc)});
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input logic [2:0] c);
    rst = r; code_valid = v; code_in = c;
    model_step(r, v, c);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 3'd2);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL reset_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
    end
    checks++;
    if ({locked, error, expected, err_count, wrap_count} !== {1'b0, 1'b0, 3'd5, 8'd0, 8'd0})
      $display("FAIL reset_values got %b %b %0d %0d %0d", locked, error, expected, err_count, wrap_count);
    else passed++;
  endtask

  task automatic test_lock();
    logic [2:0] seq[4] = '{3'd5, 3'd4, 3'd7, 3'd6};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL lock_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
      if (i == 2) begin
        checks++;
        if (locked !== 1'b0) $display("FAIL lock_early got %b exp 0", locked);
        else passed++;
      end
    end
    checks++;
    if ({locked, expected} !== {1'b1, 3'd1}) $display("FAIL lock_acquire got %b/%0d exp 1/1", locked, expected);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [2:0] seq[5] = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd5};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL wrap_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
      checks++;
      if ({error, wrap_count} !== {1'b0, (i == 4) ? 8'd1 : 8'd0})
        $display("FAIL wrap_count%0d got err=%b wrap=%0d", i, error, wrap_count);
      else passed++;
    end
  endtask

  task automatic test_single_error();
    drive(1'b0, 1'b1, 3'd3); // expected 4
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e) $display("FAIL single_bad got %h exp %h", obs_vec(), e);
    else passed++;
    checks++;
    if ({error, err_count, locked} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL single_pulse got err=%b cnt=%0d lk=%b exp 1/1/1", error, err_count, locked);
    else passed++;
    drive(1'b0, 1'b1, 3'd7);
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e) $display("FAIL single_recover got %h exp %h", obs_vec(), e);
    else passed++;
    checks++;
    if ({error, locked, err_count} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL single_after got err=%b lk=%b cnt=%0d exp 0/1/1", error, locked, err_count);
    else passed++;
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 3'd0); // expected 6 then 1
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL unlock_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
      checks++;
      if ({error, locked} !== {1'b1, (i == 0)})
        $display("FAIL unlock_flags%0d got err=%b lk=%b", i, error, locked);
      else passed++;
    end
    checks++;
    if (err_count !== 8'd3) $display("FAIL unlock_errcnt got %0d exp 3", err_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] src;
    logic [2:0] c;
    logic       v;
    logic       r;
    drive(1'b1, 1'b0, 3'd0);
    void'(exp_q.pop_front());
    src = 3'($urandom_range(0, 7));
    for (int i = 0; i < 240; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = src;
      if ($urandom_range(0, 11) == 0) c = src ^ 3'($urandom_range(1, 7));
      if (v) src = 3'(succ_tab[src]);
      drive(r, v, c);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL b2b_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    logic [2:0] lk_seq[4] = '{3'd2, 3'd5, 3'd4, 3'd7};
    drive(1'b1, 1'b0, 3'd0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, lk_seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL sat_lock%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
    end
    for (int i = 0; i < 10; i++) begin
      // alternate one bad sample and one good sample so lock is never lost
      drive(1'b0, 1'b1, (i % 2 == 0) ? (m_ex ^ 3'd1) : m_ex);
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL sat_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
    end
    checks++;
    if ({err_count_s, err_count, locked_s} !== {2'd3, 8'd5, 1'b1})
      $display("FAIL sat_value got small=%0d wide=%0d lk=%b exp 3/5/1", err_count_s, err_count, locked_s);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'($urandom_range(0, 7)));
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) $display("FAIL hold_step%0d got %h exp %h", i, obs_vec(), e);
      else passed++;
    end
    checks++;
    if ({error, locked, err_count_s, err_count} !== {1'b0, 1'b1, 2'd3, 8'd5})
      $display("FAIL hold_values got err=%b lk=%b cnt=%0d/%0d", error, locked, err_count_s, err_count);
    else passed++;
    drive(1'b1, 1'b1, m_ex);
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e) $display("FAIL rst_wins got %h exp %h", obs_vec(), e);
    else passed++;
    checks++;
    if ({locked, locked_s, error, expected, err_count, err_count_s, wrap_count, wrap_count_s}
        !== {1'b0, 1'b0, 1'b0, 3'd5, 8'd0, 2'd0, 8'd0, 2'd0})
      $display("FAIL rst_values got lk=%b err=%b exp=%0d cnt=%0d/%0d", locked, error, expected, err_count, err_count_s);
    else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_single_error();
    test_unlock();
    test_back_to_back();
    test_saturate();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
